// File: rtl/tala_pkg.sv
// Shared types and lookup helpers for the tala beat scheduler.
package tala_pkg;

  typedef enum logic [1:0] {ADI = 2'd0, RUPAKA = 2'd1, MISRA = 2'd2, KHANDA = 2'd3} tala_e;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FINISH = 2'd2} state_e;

  localparam logic [1:0] NONE = 2'b00;
  localparam logic [1:0] CLAP = 2'b01;
  localparam logic [1:0] WAVE = 2'b10;

  // Beats per avartanam.
  function automatic logic [3:0] beats_of(input tala_e t);
    case (t)
      ADI:     beats_of = 4'd8;
      RUPAKA:  beats_of = 4'd3;
      MISRA:   beats_of = 4'd7;
      default: beats_of = 4'd5;
    endcase
  endfunction

  // LED action for a given beat of a tala.
  function automatic logic [1:0] pattern_of(input tala_e t, input logic [3:0] b);
    pattern_of = NONE;
    case (t)
      ADI: begin
        if (b == 4'd0 || b == 4'd4 || b == 4'd6) pattern_of = CLAP;
        else if (b == 4'd5 || b == 4'd7)        pattern_of = WAVE;
      end
      RUPAKA:  pattern_of = (b == 4'd2) ? WAVE : CLAP;
      MISRA:   if (b == 4'd0 || b == 4'd3 || b == 4'd5) pattern_of = CLAP;
      default: if (b == 4'd0 || b == 4'd2 || b == 4'd3) pattern_of = CLAP;
    endcase
  endfunction

  // Clock ticks per beat for a tempo selection.
  function automatic logic [3:0] speed_ticks(input logic [1:0] s);
    case (s)
      2'b01:   speed_ticks = 4'd6;
      2'b10:   speed_ticks = 4'd4;
      default: speed_ticks = 4'd10;
    endcase
  endfunction

endpackage

// File: rtl/tala_beat_timer.sv
// Tick/beat sequencer. The beat period is captured at load and at every
// beat wrap, so a tempo change only takes effect on the next beat.
module tala_beat_timer
  import tala_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [1:0] tala,
  input  logic [1:0] speed_sel,
  output logic [3:0] tick,
  output logic [3:0] beat_idx,
  output logic [3:0] tper,
  output logic       beat_wrap,
  output logic       cycle_wrap
);

  assign beat_wrap  = en && (tick == tper - 4'd1);
  assign cycle_wrap = beat_wrap && (beat_idx == beats_of(tala_e'(tala)) - 4'd1);

  // Tick counter, beat index and latched beat period.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick     <= '0;
      beat_idx <= '0;
      tper     <= speed_ticks(2'b00);
    end else if (load) begin
      tick     <= '0;
      beat_idx <= '0;
      tper     <= speed_ticks(speed_sel);
    end else if (beat_wrap) begin
      tick     <= '0;
      beat_idx <= cycle_wrap ? 4'd0 : beat_idx + 4'd1;
      tper     <= speed_ticks(speed_sel);
    end else if (en) begin
      tick     <= tick + 4'd1;
    end
  end

endmodule

// File: rtl/tala_scheduler.sv
// Tala run-time controller: run FSM, cycle counting and LED decode.
// Optional build macro TALA_PAUSE_EN adds a pause input that freezes timing.
module tala_scheduler
  import tala_pkg::*;
#(
  parameter int CNT_W = 10,
  parameter int TGT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       tala_sel,
  input  logic [1:0]       speed_sel,
  input  logic [TGT_W-1:0] cycles_target,
`ifdef TALA_PAUSE_EN
  input  logic             pause,
`endif
  output logic [1:0]       led,
  output logic [3:0]       beat_idx,
  output logic             beat_tick,
  output logic             cycle_start,
  output logic [CNT_W-1:0] cycle_count,
  output logic             busy,
  output logic             done
);

  localparam int CW = ((CNT_W > TGT_W) ? CNT_W : TGT_W) + 1;

  state_e           state;
  tala_e            tala_q;
  logic [TGT_W-1:0] target_q;
  logic [3:0]       tick, tper;
  logic             beat_wrap, cycle_wrap, run_act, load, last_cycle;

  assign busy = (state != S_IDLE);
`ifdef TALA_PAUSE_EN
  assign run_act = busy && !pause;
`else
  assign run_act = busy;
`endif
  assign load       = (state == S_IDLE) && start;
  assign last_cycle = (target_q != '0) &&
                      ((CW'(cycle_count) + CW'(1)) == CW'(target_q));

  tala_beat_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .en         (run_act),
    .tala       (tala_q),
    .speed_sel  (speed_sel),
    .tick       (tick),
    .beat_idx   (beat_idx),
    .tper       (tper),
    .beat_wrap  (beat_wrap),
    .cycle_wrap (cycle_wrap)
  );

  assign beat_tick   = run_act && (tick == 4'd0);
  assign cycle_start = beat_tick && (beat_idx == 4'd0);
  assign led         = (run_act && (tick < (tper >> 1))) ? pattern_of(tala_q, beat_idx) : NONE;

  // Run FSM; ends only at a cycle wrap so the final avartanam always completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      tala_q      <= ADI;
      target_q    <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_RUN;
            tala_q      <= tala_e'(tala_sel);
            target_q    <= cycles_target;
            cycle_count <= '0;
          end
        end
        default: begin
          if (cycle_wrap) begin
            if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
          end
          if (cycle_wrap && (state == S_FINISH || last_cycle)) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else if (state == S_RUN && stop) begin
            state <= S_FINISH;
          end
        end
      endcase
    end
  end

endmodule
